adc_capture_sched: RTL and testbench
====================================

# adc_capture_sched

Single-clock capture sequencer that turns one ADC capture request (start address, byte count) into a series of AXI DataMover S2MM commands. It tracks their completion statuses and reports done, error, progress and run time to the register map. It sits between the `reg_map` ADC control registers and the S2MM command/status ports of the DataMover inside `adc_data_path`, in the `ps_clk` domain.

## Interface
Parameters:
- `CHUNK_BYTES`, 4096: maximum BTT per command; power of two, multiple of 16, ≤ 2^22.
- `MAX_OUTSTANDING`, 4: maximum number of commands accepted but without a returned status; 1..15.

Ports:
- `ps_clk`  in  1  sole clock.
- `ps_rst`  in  1  reset, asynchronous, active-high.
- `write_start`  in  1  register bit; a rising edge starts a capture.
- `write_reset`  in  1  level; abort and clear while high.
- `start_address`  in  32  byte address of the first beat; sampled on start.
- `cap_size`  in  32  capture length in bytes; sampled on start; bits [3:0] ignored.
- `m_axis_cmd_tvalid`  out  1  command valid.
- `m_axis_cmd_tready`  in  1  command ready.
- `m_axis_cmd_tdata`  out  72  S2MM command. Fields: [22:0] BTT; [23] type=1; [29:24] 0; [30] EOF=1; [31] 0; [63:32] SADDR; [67:64] TAG; [71:68] 0.
- `s_axis_sts_tvalid`  in  1  status valid.
- `s_axis_sts_tready`  out  1  status ready.
- `s_axis_sts_tdata`  in  8  status word: [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY.
- `busy`  out  1  capture in progress.
- `cap_done`  out  1  capture completed without error; held.
- `wr_mm2s_err`  out  1  error latched; held.
- `current_addr`  out  32  SADDR of the next command to be issued.
- `run_cycles`  out  32  cycles from start to DONE/ERR.
- `datamover_status`  out  8  last status word received.

## Operation
- Reset value of every output is 0, except `s_axis_sts_tready`, which is 1 one cycle after reset deasserts.
- `write_start` goes through a one-flop edge detector. A rising edge is acted on only in IDLE, DONE or ERR; otherwise it is ignored.
- On start:
  - latch `rem = cap_size & ~32'hF` and `addr = start_address`;
  - clear `cap_done`, `wr_mm2s_err`, `run_cycles`, outstanding count and tag counter;
  - go to ISSUE, or go straight to DONE if `rem == 0`.
- States:
  - IDLE: waits for start.
  - ISSUE: `m_axis_cmd_tvalid` = 1 while `rem != 0`, `outstanding < MAX_OUTSTANDING` and no error is latched. BTT = min(`CHUNK_BYTES`, `rem`). On handshake: `addr += BTT`, `rem -= BTT`, `tag += 1` (mod 16), `outstanding += 1`. When `rem` reaches 0, go to WAIT.
  - WAIT: waits for `outstanding == 0`, then goes to DONE, or to ERR if an error is latched.
  - DONE: `cap_done` = 1 and `busy` = 0. Stays here until the next start or `write_reset`.
  - ERR: `wr_mm2s_err` = 1 and `busy` = 0. Same exit conditions as DONE.
- Every accepted status decrements `outstanding` and updates `datamover_status`.
- A status is an error if any of the following holds; the error is latched:
  - OKAY = 0;
  - any of bits [6:4] is set;
  - TAG ≠ expected in-order tag (the expected tag starts at 0 and increments per status).
- Once an error is latched, issuing stops, including a command that is currently valid but not yet accepted. The FSM moves to WAIT, drains `outstanding`, then enters ERR.
- Accept and status in the same cycle leave `outstanding` unchanged.
- `write_reset` high:
  - returns to IDLE and holds there;
  - clears all outputs except `s_axis_sts_tready`;
  - drops `m_axis_cmd_tvalid` immediately. This is the only permitted withdrawal of a valid command.
- Statuses arriving in IDLE are accepted and discarded; they do not update `datamover_status`.
- `run_cycles` increments every cycle while `busy` = 1 and saturates at 2^32−1.
- `busy` = 1 in ISSUE and WAIT.

## Timing
- Edge on `write_start` at cycle N:
  - edge detected at N+1;
  - `busy` = 1 and ISSUE state from N+2;
  - first `m_axis_cmd_tvalid` at N+2.
- Back-to-back commands are possible, one per cycle while `m_axis_cmd_tready` = 1.
- `m_axis_cmd_tdata` is stable while valid is high and not yet accepted.
- The last status accepted at cycle M gives DONE/ERR at M+1, with `cap_done` or `wr_mm2s_err` visible at M+1.
- The `run_cycles` final value equals the number of cycles with `busy` = 1.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- `start_address`=0, `cap_size`=640, ready always 1, OKAY statuses echoing tags → one command: BTT=640, SADDR=0, TAG=0. `cap_done`=1, `current_addr`=640, `wr_mm2s_err`=0.
- `start_address`=0x1000, `cap_size`=10000 → three commands:
  - BTT 4096, SADDR 0x1000, TAG 0;
  - BTT 4096, SADDR 0x2000, TAG 1;
  - BTT 1808, SADDR 0x3000, TAG 2.
  - Then `cap_done`=1 and `current_addr`=0x3710.
- `MAX_OUTSTANDING`=2, `cap_size`=16384, statuses withheld → exactly 2 commands accepted and valid stays low. Release one status → a third command issues the next cycle.
- Second status carries SLVERR (0x41) → no further commands. After the outstanding statuses drain: `wr_mm2s_err`=1, `cap_done`=0, `datamover_status`=0x41.
- `write_reset` pulsed after the first command accept → same cycle+1: `busy`=0 and valid low. Late statuses are accepted but `datamover_status` stays 0. A new start then runs normally.
- `cap_size`=8 (rounds to 0) → no command. `cap_done`=1 at N+2 and `run_cycles`=0. A start pulse while `busy`=1 is ignored.

Source files
------------

// File: rtl/adc_capture_sched.sv
// ADC capture sequencer: splits one capture request into AXI DataMover S2MM
// commands, checks their in-order statuses and reports progress and result.
module adc_capture_sched #(
    parameter int unsigned CHUNK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        ps_clk,
    input  logic        ps_rst,
    input  logic        write_start,
    input  logic        write_reset,
    input  logic [31:0] start_address,
    input  logic [31:0] cap_size,
    output logic        m_axis_cmd_tvalid,
    input  logic        m_axis_cmd_tready,
    output logic [71:0] m_axis_cmd_tdata,
    input  logic        s_axis_sts_tvalid,
    output logic        s_axis_sts_tready,
    input  logic [7:0]  s_axis_sts_tdata,
    output logic        busy,
    output logic        cap_done,
    output logic        wr_mm2s_err,
    output logic [31:0] current_addr,
    output logic [31:0] run_cycles,
    output logic [7:0]  datamover_status
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [31:0] CHUNK_W   = 32'(CHUNK_BYTES);
    localparam logic [22:0] CHUNK_BTT = 23'(CHUNK_BYTES);
    localparam logic [3:0]  MAX_OUT_W = 4'(MAX_OUTSTANDING);

    // Command word: type=1 (INCR) and EOF=1 are fixed, reserved fields zero.
    function automatic logic [71:0] pack_cmd(input logic [22:0] btt,
                                             input logic [31:0] saddr,
                                             input logic [3:0]  tag);
        pack_cmd = {4'd0, tag, saddr, 1'b0, 1'b1, 6'd0, 1'b1, btt};
    endfunction

    function automatic logic sts_is_err(input logic [7:0] sts,
                                        input logic [3:0] exp_tag);
        sts_is_err = (~sts[7]) | (|sts[6:4]) | (sts[3:0] != exp_tag);
    endfunction

    state_t      state_r, state_nxt_s;
    logic        start_sync_r, start_prev_r;
    logic [31:0] rem_r, rem_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [3:0]  tag_r, tag_nxt_s;
    logic [3:0]  exp_tag_r, exp_tag_nxt_s;
    logic [3:0]  out_r, out_nxt_s;
    logic        err_r, err_nxt_s;
    logic [7:0]  dm_status_r, dm_status_nxt_s;
    logic        cmd_valid_r, cmd_valid_nxt_s;
    logic [71:0] cmd_data_r, cmd_data_nxt_s;
    logic        sts_ready_r;
    logic        busy_r, cap_done_r, mm2s_err_r;
    logic [31:0] run_cycles_r;

    logic        start_edge_s, idle_like_s, start_ok_s;
    logic        cmd_fire_s, sts_take_s, sts_dec_s, busy_st_s;
    logic [22:0] btt_s, btt_nxt_s;

    assign start_edge_s = start_sync_r & ~start_prev_r;
    assign idle_like_s  = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR);
    assign start_ok_s   = start_edge_s & idle_like_s & ~write_reset;
    assign cmd_fire_s   = cmd_valid_r & m_axis_cmd_tready;
    assign sts_take_s   = s_axis_sts_tvalid & sts_ready_r & (state_r != ST_IDLE);
    assign sts_dec_s    = sts_take_s & (out_r != 4'd0);
    assign busy_st_s    = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign btt_s        = (rem_r > CHUNK_W) ? CHUNK_BTT : rem_r[22:0];
    assign btt_nxt_s    = (rem_nxt_s > CHUNK_W) ? CHUNK_BTT : rem_nxt_s[22:0];

    // Next-state, datapath and status bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        rem_nxt_s       = rem_r;
        addr_nxt_s      = addr_r;
        tag_nxt_s       = tag_r;
        exp_tag_nxt_s   = exp_tag_r;
        out_nxt_s       = out_r;
        err_nxt_s       = err_r;
        dm_status_nxt_s = dm_status_r;
        if (write_reset) begin
            state_nxt_s     = ST_IDLE;
            rem_nxt_s       = 32'd0;
            addr_nxt_s      = 32'd0;
            tag_nxt_s       = 4'd0;
            exp_tag_nxt_s   = 4'd0;
            out_nxt_s       = 4'd0;
            err_nxt_s       = 1'b0;
            dm_status_nxt_s = 8'd0;
        end else if (start_ok_s) begin
            rem_nxt_s     = cap_size & ~32'hF;
            addr_nxt_s    = start_address;
            tag_nxt_s     = 4'd0;
            exp_tag_nxt_s = 4'd0;
            out_nxt_s     = 4'd0;
            err_nxt_s     = 1'b0;
            if (cap_size[31:4] == 28'd0) begin
                state_nxt_s = ST_DONE;
            end else begin
                state_nxt_s = ST_ISSUE;
            end
        end else begin
            if (cmd_fire_s) begin
                addr_nxt_s = addr_r + {9'd0, btt_s};
                rem_nxt_s  = rem_r - {9'd0, btt_s};
                tag_nxt_s  = tag_r + 4'd1;
            end else begin
                addr_nxt_s = addr_r;
            end
            out_nxt_s = out_r + {3'd0, cmd_fire_s} - {3'd0, sts_dec_s};
            if (sts_take_s) begin
                dm_status_nxt_s = s_axis_sts_tdata;
                exp_tag_nxt_s   = exp_tag_r + 4'd1;
                if (busy_st_s && sts_is_err(s_axis_sts_tdata, exp_tag_r)) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end else begin
                dm_status_nxt_s = dm_status_r;
            end
            // Draining the last outstanding status finishes the capture on the next cycle.
            case (state_r)
                ST_ISSUE: begin
                    if ((rem_nxt_s == 32'd0) || err_nxt_s) begin
                        if (out_nxt_s == 4'd0) begin
                            state_nxt_s = err_nxt_s ? ST_ERR : ST_DONE;
                        end else begin
                            state_nxt_s = ST_WAIT;
                        end
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (out_nxt_s == 4'd0) begin
                        state_nxt_s = err_nxt_s ? ST_ERR : ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                default: state_nxt_s = state_r;
            endcase
        end
        cmd_valid_nxt_s = (state_nxt_s == ST_ISSUE) && (rem_nxt_s != 32'd0) &&
                          (out_nxt_s < MAX_OUT_W) && !err_nxt_s;
        if (cmd_valid_nxt_s) begin
            cmd_data_nxt_s = pack_cmd(btt_nxt_s, addr_nxt_s, tag_nxt_s);
        end else begin
            cmd_data_nxt_s = 72'd0;
        end
    end

    // Sequencer state and capture datapath registers.
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            state_r      <= ST_IDLE;
            start_sync_r <= 1'b0;
            start_prev_r <= 1'b0;
            rem_r        <= 32'd0;
            addr_r       <= 32'd0;
            tag_r        <= 4'd0;
            exp_tag_r    <= 4'd0;
            out_r        <= 4'd0;
            err_r        <= 1'b0;
            dm_status_r  <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            start_sync_r <= write_start;
            start_prev_r <= start_sync_r;
            rem_r        <= rem_nxt_s;
            addr_r       <= addr_nxt_s;
            tag_r        <= tag_nxt_s;
            exp_tag_r    <= exp_tag_nxt_s;
            out_r        <= out_nxt_s;
            err_r        <= err_nxt_s;
            dm_status_r  <= dm_status_nxt_s;
        end
    end

    // Registered interface and status outputs.
    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) begin
            cmd_valid_r  <= 1'b0;
            cmd_data_r   <= 72'd0;
            sts_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            cap_done_r   <= 1'b0;
            mm2s_err_r   <= 1'b0;
            run_cycles_r <= 32'd0;
        end else begin
            cmd_valid_r  <= cmd_valid_nxt_s;
            cmd_data_r   <= cmd_data_nxt_s;
            sts_ready_r  <= 1'b1;
            busy_r       <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT);
            cap_done_r   <= (state_nxt_s == ST_DONE);
            mm2s_err_r   <= (state_nxt_s == ST_ERR);
            if (write_reset || start_ok_s) begin
                run_cycles_r <= 32'd0;
            end else if (busy_r && (run_cycles_r != 32'hFFFF_FFFF)) begin
                run_cycles_r <= run_cycles_r + 32'd1;
            end else begin
                run_cycles_r <= run_cycles_r;
            end
        end
    end

    assign m_axis_cmd_tvalid = cmd_valid_r;
    assign m_axis_cmd_tdata  = cmd_data_r;
    assign s_axis_sts_tready = sts_ready_r;
    assign busy              = busy_r;
    assign cap_done          = cap_done_r;
    assign wr_mm2s_err       = mm2s_err_r;
    assign current_addr      = addr_r;
    assign run_cycles        = run_cycles_r;
    assign datamover_status  = dm_status_r;

endmodule

// File: tb/tb_adc_capture_sched.sv
// Directed bench for adc_capture_sched (CHUNK_BYTES=4096, MAX_OUTSTANDING=2).
module tb_adc_capture_sched;

    logic        ps_clk;
    logic        ps_rst;
    logic        write_start;
    logic        write_reset;
    logic [31:0] start_address;
    logic [31:0] cap_size;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [71:0] m_axis_cmd_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        busy;
    logic        cap_done;
    logic        wr_mm2s_err;
    logic [31:0] current_addr;
    logic [31:0] run_cycles;
    logic [7:0]  datamover_status;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [71:0] cmd_q[$];
    int          cmd_cyc_q[$];

    adc_capture_sched #(.CHUNK_BYTES(4096), .MAX_OUTSTANDING(2)) dut (
        .ps_clk(ps_clk), .ps_rst(ps_rst),
        .write_start(write_start), .write_reset(write_reset),
        .start_address(start_address), .cap_size(cap_size),
        .m_axis_cmd_tvalid(m_axis_cmd_tvalid), .m_axis_cmd_tready(m_axis_cmd_tready),
        .m_axis_cmd_tdata(m_axis_cmd_tdata),
        .s_axis_sts_tvalid(s_axis_sts_tvalid), .s_axis_sts_tready(s_axis_sts_tready),
        .s_axis_sts_tdata(s_axis_sts_tdata),
        .busy(busy), .cap_done(cap_done), .wr_mm2s_err(wr_mm2s_err),
        .current_addr(current_addr), .run_cycles(run_cycles),
        .datamover_status(datamover_status)
    );

    initial ps_clk = 1'b0;
    always #5 ps_clk = ~ps_clk;

    // Log every accepted command with the cycle it was accepted in.
    always @(posedge ps_clk) begin
        cyc <= cyc + 1;
        if (m_axis_cmd_tvalid && m_axis_cmd_tready) begin
            cmd_q.push_back(m_axis_cmd_tdata);
            cmd_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] exp_cmd(input logic [22:0] btt, input logic [31:0] addr,
                                            input logic [3:0] tag);
        return {4'h0, tag, addr, 32'h4080_0000 | {9'd0, btt}};
    endfunction

    task automatic tick();
        @(posedge ps_clk);
        #1;
    endtask

    task automatic start_cap(input logic [31:0] addr, input logic [31:0] size);
        start_address = addr;
        cap_size      = size;
        write_start   = 1'b1;
        tick();
        write_start   = 1'b0;
        tick();
    endtask

    task automatic send_sts(input logic [7:0] sts);
        s_axis_sts_tvalid = 1'b1;
        s_axis_sts_tdata  = sts;
        tick();
        s_axis_sts_tvalid = 1'b0;
        s_axis_sts_tdata  = 8'h00;
    endtask

    task automatic wait_cmds(input int n);
        for (int i = 0; i < 40 && cmd_q.size() < n; i++) tick();
        checks++;
        if (cmd_q.size() < n) begin
            errors++;
            $display("FAIL wait_cmds: got %0d commands, expected %0d", cmd_q.size(), n);
        end
    endtask

    task automatic test_reset();
        ps_rst = 1'b1;
        write_start = 1'b0; write_reset = 1'b0;
        start_address = 32'd0; cap_size = 32'd0;
        m_axis_cmd_tready = 1'b0; s_axis_sts_tvalid = 1'b0; s_axis_sts_tdata = 8'h00;
        #22;
        checks++; if ({m_axis_cmd_tvalid, s_axis_sts_tready, busy, cap_done, wr_mm2s_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000",
                {m_axis_cmd_tvalid, s_axis_sts_tready, busy, cap_done, wr_mm2s_err}); end
        checks++; if ({current_addr, run_cycles, datamover_status, m_axis_cmd_tdata} !== 144'd0) begin
            errors++; $display("FAIL reset_words: addr %h run %h sts %h cmd %h",
                current_addr, run_cycles, datamover_status, m_axis_cmd_tdata); end
        @(posedge ps_clk); #1;
        ps_rst = 1'b0;
        tick();
        checks++; if (s_axis_sts_tready !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b expected 1", s_axis_sts_tready); end
    endtask

    task automatic test_single();
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_address = 32'd0; cap_size = 32'd640; write_start = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_n1: got %b expected 0", busy); end
        write_start = 1'b0;
        tick();
        checks++; if ({busy, m_axis_cmd_tvalid} !== 2'b11) begin
            errors++; $display("FAIL single_busy_valid_n2: got %b expected 11", {busy, m_axis_cmd_tvalid}); end
        checks++; if (m_axis_cmd_tdata !== exp_cmd(23'd640, 32'd0, 4'd0)) begin
            errors++; $display("FAIL single_cmd: got %h expected %h", m_axis_cmd_tdata, exp_cmd(23'd640, 32'd0, 4'd0)); end
        tick();
        checks++; if (m_axis_cmd_tvalid !== 1'b0 || cmd_q.size() != 1) begin
            errors++; $display("FAIL single_one_cmd: valid %b count %0d expected 0 and 1", m_axis_cmd_tvalid, cmd_q.size()); end
        send_sts(8'h80);
        checks++; if ({cap_done, wr_mm2s_err, busy} !== 3'b100) begin
            errors++; $display("FAIL single_done: got %b expected 100", {cap_done, wr_mm2s_err, busy}); end
        checks++; if (current_addr !== 32'd640) begin
            errors++; $display("FAIL single_addr: got %0d expected 640", current_addr); end
        checks++; if (run_cycles !== 32'd2) begin
            errors++; $display("FAIL single_run_cycles: got %0d expected 2", run_cycles); end
        checks++; if (datamover_status !== 8'h80) begin
            errors++; $display("FAIL single_status: got %h expected 80", datamover_status); end
    endtask

    task automatic test_multi();
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_cap(32'h1000, 32'd10000);
        wait_cmds(2);
        send_sts(8'h80);
        wait_cmds(3);
        send_sts(8'h81);
        send_sts(8'h82);
        checks++; if (cmd_q[0] !== exp_cmd(23'd4096, 32'h1000, 4'd0)) begin
            errors++; $display("FAIL multi_cmd0: got %h expected %h", cmd_q[0], exp_cmd(23'd4096, 32'h1000, 4'd0)); end
        checks++; if (cmd_q[1] !== exp_cmd(23'd4096, 32'h2000, 4'd1)) begin
            errors++; $display("FAIL multi_cmd1: got %h expected %h", cmd_q[1], exp_cmd(23'd4096, 32'h2000, 4'd1)); end
        checks++; if (cmd_q[2] !== exp_cmd(23'd1808, 32'h3000, 4'd2)) begin
            errors++; $display("FAIL multi_cmd2: got %h expected %h", cmd_q[2], exp_cmd(23'd1808, 32'h3000, 4'd2)); end
        checks++; if (cmd_cyc_q[1] - cmd_cyc_q[0] != 1) begin
            errors++; $display("FAIL back_to_back: gap %0d expected 1", cmd_cyc_q[1] - cmd_cyc_q[0]); end
        checks++; if ({cap_done, wr_mm2s_err} !== 2'b10 || current_addr !== 32'h3710) begin
            errors++; $display("FAIL multi_done: done/err %b addr %h expected 10 and 3710",
                {cap_done, wr_mm2s_err}, current_addr); end
    endtask

    task automatic test_outstanding();
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_cap(32'd0, 32'd16384);
        repeat (6) tick();
        checks++; if (cmd_q.size() != 2 || m_axis_cmd_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL outstanding_limit: count %0d valid %b busy %b expected 2 0 1",
                cmd_q.size(), m_axis_cmd_tvalid, busy); end
        send_sts(8'h80);
        checks++; if (m_axis_cmd_tvalid !== 1'b1 || m_axis_cmd_tdata !== exp_cmd(23'd4096, 32'h2000, 4'd2)) begin
            errors++; $display("FAIL outstanding_release: valid %b cmd %h expected 1 %h",
                m_axis_cmd_tvalid, m_axis_cmd_tdata, exp_cmd(23'd4096, 32'h2000, 4'd2)); end
        tick();
        send_sts(8'h81);
        wait_cmds(4);
        send_sts(8'h82);
        send_sts(8'h83);
        checks++; if (cmd_q[3] !== exp_cmd(23'd4096, 32'h3000, 4'd3)) begin
            errors++; $display("FAIL outstanding_cmd3: got %h expected %h", cmd_q[3], exp_cmd(23'd4096, 32'h3000, 4'd3)); end
        checks++; if (cap_done !== 1'b1 || current_addr !== 32'h4000) begin
            errors++; $display("FAIL outstanding_done: done %b addr %h expected 1 4000", cap_done, current_addr); end
    endtask

    task automatic test_error();
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_cap(32'd0, 32'd16384);
        wait_cmds(2);
        m_axis_cmd_tready = 1'b0;
        send_sts(8'h80);
        tick();
        checks++; if (m_axis_cmd_tvalid !== 1'b1 || m_axis_cmd_tdata !== exp_cmd(23'd4096, 32'h2000, 4'd2)) begin
            errors++; $display("FAIL error_pending_cmd: valid %b cmd %h expected 1 %h",
                m_axis_cmd_tvalid, m_axis_cmd_tdata, exp_cmd(23'd4096, 32'h2000, 4'd2)); end
        send_sts(8'h41);
        checks++; if ({m_axis_cmd_tvalid, wr_mm2s_err, cap_done, busy} !== 4'b0100) begin
            errors++; $display("FAIL error_state: valid/err/done/busy %b expected 0100",
                {m_axis_cmd_tvalid, wr_mm2s_err, cap_done, busy}); end
        checks++; if (datamover_status !== 8'h41) begin
            errors++; $display("FAIL error_status: got %h expected 41", datamover_status); end
        m_axis_cmd_tready = 1'b1;
        repeat (3) tick();
        checks++; if (cmd_q.size() != 2 || wr_mm2s_err !== 1'b1) begin
            errors++; $display("FAIL error_no_issue: count %0d err %b expected 2 1", cmd_q.size(), wr_mm2s_err); end
    endtask

    task automatic test_write_reset();
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_cap(32'h100, 32'd8192);
        tick();
        m_axis_cmd_tready = 1'b0;
        write_reset = 1'b1;
        tick();
        checks++; if ({busy, m_axis_cmd_tvalid, cap_done, wr_mm2s_err} !== 4'b0000 ||
                      current_addr !== 32'd0 || run_cycles !== 32'd0) begin
            errors++; $display("FAIL wreset_clear: flags %b addr %h run %0d expected 0000 0 0",
                {busy, m_axis_cmd_tvalid, cap_done, wr_mm2s_err}, current_addr, run_cycles); end
        write_reset = 1'b0;
        send_sts(8'h80);
        checks++; if (datamover_status !== 8'h00 || s_axis_sts_tready !== 1'b1 || cmd_q.size() != 1) begin
            errors++; $display("FAIL wreset_late_sts: sts %h ready %b count %0d expected 00 1 1",
                datamover_status, s_axis_sts_tready, cmd_q.size()); end
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_cap(32'd0, 32'd640);
        wait_cmds(1);
        checks++; if (cmd_q[0] !== exp_cmd(23'd640, 32'd0, 4'd0)) begin
            errors++; $display("FAIL wreset_restart_cmd: got %h expected %h", cmd_q[0], exp_cmd(23'd640, 32'd0, 4'd0)); end
        send_sts(8'h80);
        checks++; if (cap_done !== 1'b1 || current_addr !== 32'd640) begin
            errors++; $display("FAIL wreset_restart_done: done %b addr %0d expected 1 640", cap_done, current_addr); end
    endtask

    task automatic test_zero_and_ignore();
        write_reset = 1'b1;
        tick();
        write_reset = 1'b0;
        cmd_q.delete(); cmd_cyc_q.delete();
        m_axis_cmd_tready = 1'b1;
        start_address = 32'h40; cap_size = 32'd8; write_start = 1'b1;
        tick();
        checks++; if (cap_done !== 1'b0) begin
            errors++; $display("FAIL zero_done_n1: got %b expected 0", cap_done); end
        write_start = 1'b0;
        tick();
        checks++; if ({cap_done, busy, m_axis_cmd_tvalid} !== 3'b100 || run_cycles !== 32'd0) begin
            errors++; $display("FAIL zero_done_n2: done/busy/valid %b run %0d expected 100 0",
                {cap_done, busy, m_axis_cmd_tvalid}, run_cycles); end
        m_axis_cmd_tready = 1'b0;
        start_cap(32'd0, 32'd10000);
        start_address = 32'h8000; cap_size = 32'd32; write_start = 1'b1;
        tick();
        write_start = 1'b0;
        repeat (3) tick();
        m_axis_cmd_tready = 1'b1;
        wait_cmds(1);
        checks++; if (cmd_q[0] !== exp_cmd(23'd4096, 32'd0, 4'd0) || cmd_q.size() != 1) begin
            errors++; $display("FAIL ignore_start: got %h count %0d expected %h 1",
                cmd_q[0], cmd_q.size(), exp_cmd(23'd4096, 32'd0, 4'd0)); end
        write_reset = 1'b1;
        tick();
        write_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_outstanding();
        test_error();
        test_write_reset();
        test_zero_and_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
